// File: rtl/gb_leaf_periph.sv
// Ghostbus leaf peripheral. It decodes the low RD+1 address bits of the window
// that the parent decoder has already selected. The lower half of the window
// holds a small CSR bank. The upper half maps a single-port RAM. The block also
// counts rising edges of an asynchronous status input.
module gb_leaf_periph #(
    parameter int          AW = 24,
    parameter int          DW = 32,
    parameter int          GW = 8,
    parameter int          RD = 5,
    parameter logic [31:0] ID = 32'h0000_BA2F
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] gb_addr,
    input  logic [DW-1:0] gb_wdata,
    output logic [DW-1:0] gb_rdata,
    input  logic          gb_we,
    input  logic          gb_wstb,
    input  logic          gb_rstb,
    input  logic          demo_sig,
    output logic          ctrl_out
);

    localparam int DEPTH = 1 << RD;

    // Local address decode. Bit RD picks the RAM half of the window.
    logic [RD:0]   a;
    logic          ram_hit;
    logic [RD-1:0] idx;
    logic          wr_en;
    logic          wr_ctrl;
    logic          wr_edgecnt;

    assign a          = gb_addr[RD:0];
    assign ram_hit    = a[RD];
    assign idx        = a[RD-1:0];
    assign wr_en      = gb_we & gb_wstb;
    assign wr_ctrl    = wr_en & ~ram_hit & (idx == RD'(1));
    assign wr_edgecnt = wr_en & ~ram_hit & (idx == RD'(3));

    // The parent has already matched the upper address bits, so they are ignored here.
    logic unused_addr;
    assign unused_addr = ^gb_addr[AW-1:RD+1];

    // ------------------------------------------------------------------
    // CTRL register
    // ------------------------------------------------------------------
    logic [DW-1:0] ctrl_q, ctrl_d;

    // Next CTRL value: load the full bus word on a qualified write.
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d = gb_wdata;
        end
    end

    // CTRL state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ctrl_q <= '0;
        else     ctrl_q <= ctrl_d;
    end

    assign ctrl_out = ctrl_q[0];

    // ------------------------------------------------------------------
    // demo_sig synchronizer and edge counter
    // ------------------------------------------------------------------
    // sync_q[0] = s1, sync_q[1] = s2 (the synchronized level), sync_q[2] = s3 (edge reference).
    logic [2:0]  sync_q, sync_d;
    logic        rise;
    logic [15:0] edgecnt_q, edgecnt_d;

    assign sync_d = {sync_q[1:0], demo_sig};
    assign rise   = sync_q[1] & ~sync_q[2];

    // Shift demo_sig through the synchronizer and the edge-detect flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    // Edge count next state. A clearing write beats a same-cycle edge.
    always_comb begin
        edgecnt_d = edgecnt_q;
        if (wr_edgecnt)  edgecnt_d = '0;
        else if (rise)   edgecnt_d = edgecnt_q + 16'd1;
    end

    // Edge counter register. It wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) edgecnt_q <= '0;
        else     edgecnt_q <= edgecnt_d;
    end

    // ------------------------------------------------------------------
    // CSR read path
    // ------------------------------------------------------------------
    logic [DW-1:0] csr_val;
    logic [DW-1:0] csr_rdata_q, csr_rdata_d;
    logic          sel_ram_q, sel_ram_d;

    // Select the CSR read value. Reserved addresses and the RAM half read as 0 here.
    always_comb begin
        csr_val = '0;
        if (!ram_hit) begin
            case (idx)
                RD'(0):  csr_val = DW'(ID);
                RD'(1):  csr_val = ctrl_q;
                RD'(2):  csr_val = DW'(sync_q[1]);
                RD'(3):  csr_val = DW'(edgecnt_q);
                default: csr_val = '0;
            endcase
        end
    end

    // Capture the read on a read strobe and hold it otherwise. The output mux
    // also remembers whether the RAM or the CSR bank was addressed.
    always_comb begin
        csr_rdata_d = csr_rdata_q;
        sel_ram_d   = sel_ram_q;
        if (gb_rstb) begin
            csr_rdata_d = csr_val;
            sel_ram_d   = ram_hit;
        end
    end

    // CSR read data and read-source registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_rdata_q <= '0;
            sel_ram_q   <= 1'b0;
        end else begin
            csr_rdata_q <= csr_rdata_d;
            sel_ram_q   <= sel_ram_d;
        end
    end

    // ------------------------------------------------------------------
    // Single-port RAM, read-first, registered read
    // ------------------------------------------------------------------
    logic [GW-1:0] mem [DEPTH];
    logic [GW-1:0] ram_rdata_q;

    // RAM write and registered read. The old word is returned on a same-address
    // read/write. Reset blocks any write at that edge, but the array contents are kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_rdata_q <= '0;
        end else begin
            if (wr_en && ram_hit) begin
                mem[idx] <= gb_wdata[GW-1:0];
            end
            if (gb_rstb && ram_hit) begin
                ram_rdata_q <= mem[idx];
            end
        end
    end

    assign gb_rdata = sel_ram_q ? DW'(ram_rdata_q) : csr_rdata_q;

endmodule

// File: tb/tb_gb_leaf_periph.sv
// Testbench for gb_leaf_periph with its default parameters (AW=24, DW=32, GW=8, RD=5).
// A reference model holds CTRL, the RAM, EDGECNT and the demo_sig level as plain
// variables. The model decides the read value from the address-map rules.
module tb_gb_leaf_periph;

    localparam logic [31:0] ID_VAL = 32'h0000_BA2F;

    logic        clk;
    logic        rst;
    logic [23:0] gb_addr;
    logic [31:0] gb_wdata;
    logic [31:0] gb_rdata;
    logic        gb_we;
    logic        gb_wstb;
    logic        gb_rstb;
    logic        demo_sig;
    logic        ctrl_out;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] ctrl_m;
    logic [7:0]  mem_m [32];
    logic [15:0] edgecnt_m;
    logic        level_m;

    gb_leaf_periph #(.AW(24), .DW(32), .GW(8), .RD(5), .ID(32'h0000_BA2F)) dut (
        .clk      (clk),
        .rst      (rst),
        .gb_addr  (gb_addr),
        .gb_wdata (gb_wdata),
        .gb_rdata (gb_rdata),
        .gb_we    (gb_we),
        .gb_wstb  (gb_wstb),
        .gb_rstb  (gb_rstb),
        .demo_sig (demo_sig),
        .ctrl_out (ctrl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value from the address map. Only the low 6 address bits matter.
    function automatic logic [31:0] model_read(input logic [23:0] addr);
        int w;
        w = int'(addr % 64);
        if (w >= 32)      return {24'd0, mem_m[w - 32]};
        else if (w == 0)  return ID_VAL;
        else if (w == 1)  return ctrl_m;
        else if (w == 2)  return {31'd0, level_m};
        else if (w == 3)  return {16'd0, edgecnt_m};
        else              return 32'd0;
    endfunction

    // Apply a committed write to the model.
    task automatic model_write(input logic [23:0] addr, input logic [31:0] data);
        int w;
        w = int'(addr % 64);
        if (w >= 32)      mem_m[w - 32] = data[7:0];
        else if (w == 1)  ctrl_m = data;
        else if (w == 3)  edgecnt_m = 16'd0;
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_write(input logic [23:0] addr, input logic [31:0] data);
        gb_addr = addr; gb_wdata = data; gb_we = 1'b1; gb_wstb = 1'b1;
        @(posedge clk); #1;
        gb_we = 1'b0; gb_wstb = 1'b0;
        model_write(addr, data);
    endtask

    task automatic bus_read(input logic [23:0] addr, output logic [31:0] data);
        gb_addr = addr; gb_rstb = 1'b1;
        @(posedge clk); #1;
        gb_rstb = 1'b0;
        data = gb_rdata;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (gb_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", gb_rdata, 32'd0); end
        checks++;
        if (ctrl_out !== 1'b0) begin failures++; $display("FAIL reset_ctrl_out got=%b exp=0", ctrl_out); end
        rst = 1'b0;
        ctrl_m = 32'd0; edgecnt_m = 16'd0; level_m = 1'b0;
        bus_read(24'd0, rd);
        checks++;
        if (rd !== ID_VAL) begin failures++; $display("FAIL reset_id got=%h exp=%h", rd, ID_VAL); end
        bus_read(24'd1, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", rd, 32'd0); end
        bus_read(24'd3, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("FAIL reset_edgecnt got=%h exp=%h", rd, 32'd0); end
        $display("test_reset done");
    endtask

    task automatic test_csr;
        logic [31:0] rd;
        logic [31:0] v;
        bus_write(24'd1, 32'hDEAD_BEE1);
        checks++;
        if (ctrl_out !== 1'b1) begin failures++; $display("FAIL csr_ctrl_out got=%b exp=1", ctrl_out); end
        bus_read(24'd1, rd);
        checks++;
        if (rd !== 32'hDEAD_BEE1) begin failures++; $display("FAIL csr_ctrl_rb got=%h exp=%h", rd, 32'hDEAD_BEE1); end
        bus_write(24'd0, 32'h1234_5678);
        bus_read(24'd0, rd);
        checks++;
        if (rd !== ID_VAL) begin failures++; $display("FAIL csr_id_ro got=%h exp=%h", rd, ID_VAL); end
        bus_write(24'd2, 32'hFFFF_FFFF);
        bus_read(24'd2, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("FAIL csr_status_ro got=%h exp=%h", rd, 32'd0); end
        bus_write(24'd5, 32'hCAFE_F00D);
        bus_read(24'd5, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("FAIL csr_reserved got=%h exp=%h", rd, 32'd0); end
        // Random CTRL values, including an even value that drives ctrl_out low.
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            if (i == 0) v[0] = 1'b0;
            bus_write(24'd1, v);
            checks++;
            if (ctrl_out !== ctrl_m[0]) begin failures++; $display("FAIL csr_ctrl_out_rand got=%b exp=%b", ctrl_out, ctrl_m[0]); end
            bus_read(24'd1, rd);
            checks++;
            if (rd !== ctrl_m) begin failures++; $display("FAIL csr_ctrl_rand got=%h exp=%h", rd, ctrl_m); end
        end
        $display("test_csr done");
    endtask

    task automatic test_ram;
        logic [31:0] rd;
        // Fill every entry so that all later RAM reads have a known value.
        for (int i = 0; i < 32; i++) bus_write(24'(32 + i), $urandom);
        bus_write(24'd32, 32'h0000_00A5);
        bus_write(24'd63, 32'h0000_003C);
        bus_read(24'd32, rd);
        checks++;
        if (rd !== 32'h0000_00A5) begin failures++; $display("FAIL ram_32 got=%h exp=%h", rd, 32'hA5); end
        bus_read(24'd63, rd);
        checks++;
        if (rd !== 32'h0000_003C) begin failures++; $display("FAIL ram_63 got=%h exp=%h", rd, 32'h3C); end
        bus_write(24'd40, 32'hFFFF_FF12);
        bus_read(24'd40, rd);
        checks++;
        if (rd !== 32'h0000_0012) begin failures++; $display("FAIL ram_zext got=%h exp=%h", rd, 32'h12); end
        // Same-cycle read and write of address 32 returns the old data.
        gb_addr = 24'd32; gb_wdata = 32'h0000_0077; gb_we = 1'b1; gb_wstb = 1'b1; gb_rstb = 1'b1;
        @(posedge clk); #1;
        gb_we = 1'b0; gb_wstb = 1'b0; gb_rstb = 1'b0;
        checks++;
        if (gb_rdata !== 32'h0000_00A5) begin failures++; $display("FAIL ram_read_first got=%h exp=%h", gb_rdata, 32'hA5); end
        model_write(24'd32, 32'h77);
        bus_read(24'd32, rd);
        checks++;
        if (rd !== 32'h0000_0077) begin failures++; $display("FAIL ram_after_rw got=%h exp=%h", rd, 32'h77); end
        // Same-cycle read and write of CTRL returns the old CTRL.
        gb_addr = 24'd1; gb_wdata = ~ctrl_m; gb_we = 1'b1; gb_wstb = 1'b1; gb_rstb = 1'b1;
        @(posedge clk); #1;
        gb_we = 1'b0; gb_wstb = 1'b0; gb_rstb = 1'b0;
        checks++;
        if (gb_rdata !== ctrl_m) begin failures++; $display("FAIL ctrl_read_first got=%h exp=%h", gb_rdata, ctrl_m); end
        model_write(24'd1, ~ctrl_m);
        $display("test_ram done");
    endtask

    task automatic test_addr_alias;
        logic [31:0] rd;
        bus_write(24'hFFFF21, 32'h0000_00C9);
        bus_read(24'd33, rd);
        checks++;
        if (rd !== 32'h0000_00C9) begin failures++; $display("FAIL alias_wr got=%h exp=%h", rd, 32'hC9); end
        bus_write(24'd33, 32'h0000_005E);
        bus_read(24'hFFFF21, rd);
        checks++;
        if (rd !== 32'h0000_005E) begin failures++; $display("FAIL alias_rd got=%h exp=%h", rd, 32'h5E); end
        // Write enable without the write strobe must not change anything.
        gb_addr = 24'd33; gb_wdata = 32'h0000_0011; gb_we = 1'b1; gb_wstb = 1'b0;
        @(posedge clk); #1;
        gb_addr = 24'd1; gb_wdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        gb_we = 1'b0;
        bus_read(24'd33, rd);
        checks++;
        if (rd !== 32'h0000_005E) begin failures++; $display("FAIL we_no_stb_ram got=%h exp=%h", rd, 32'h5E); end
        bus_read(24'd1, rd);
        checks++;
        if (rd !== ctrl_m) begin failures++; $display("FAIL we_no_stb_ctrl got=%h exp=%h", rd, ctrl_m); end
        $display("test_addr_alias done");
    endtask

    task automatic test_random;
        logic [31:0] exp_rd;
        logic [23:0] addr;
        logic [31:0] data;
        logic        we, stb, rstb;
        exp_rd = gb_rdata;
        for (int i = 0; i < 200; i++) begin
            addr = {18'($urandom), 6'($urandom_range(0, 63))};
            if ($urandom_range(0, 1) == 0) addr[5:0] = 6'($urandom_range(0, 5));
            data = $urandom;
            we   = 1'($urandom);
            stb  = 1'($urandom);
            rstb = 1'($urandom);
            gb_addr = addr; gb_wdata = data; gb_we = we; gb_wstb = stb; gb_rstb = rstb;
            if (rstb) exp_rd = model_read(addr);
            @(posedge clk); #1;
            if (we && stb) model_write(addr, data);
            checks++;
            if (gb_rdata !== exp_rd) begin
                failures++;
                $display("FAIL random_txn i=%0d addr=%h we=%b stb=%b rstb=%b got=%h exp=%h", i, addr, we, stb, rstb, gb_rdata, exp_rd);
            end
            if (ctrl_out !== ctrl_m[0]) begin
                failures++;
                $display("FAIL random_ctrl_out i=%0d got=%b exp=%b", i, ctrl_out, ctrl_m[0]);
            end
            checks++;
        end
        gb_we = 1'b0; gb_wstb = 1'b0; gb_rstb = 1'b0;
        $display("test_random done");
    endtask

    task automatic test_edgecnt;
        logic [31:0] rd;
        int n;
        bus_write(24'd3, 32'd0);
        // Rising level: STATUS read shows the new value from the third edge on.
        demo_sig = 1'b1; gb_addr = 24'd2; gb_rstb = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (gb_rdata !== ((k >= 3) ? 32'd1 : 32'd0)) begin failures++; $display("FAIL status_rise k=%0d got=%h exp=%h", k, gb_rdata, (k >= 3) ? 32'd1 : 32'd0); end
        end
        edgecnt_m = edgecnt_m + 16'd1;
        demo_sig = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (gb_rdata !== ((k >= 3) ? 32'd0 : 32'd1)) begin failures++; $display("FAIL status_fall k=%0d got=%h exp=%h", k, gb_rdata, (k >= 3) ? 32'd0 : 32'd1); end
        end
        gb_rstb = 1'b0;
        // Two more pulses of random width give three edges in total.
        n = 2;
        for (int p = 0; p < n; p++) begin
            demo_sig = 1'b1;
            repeat ($urandom_range(3, 6)) @(posedge clk);
            #1;
            edgecnt_m = edgecnt_m + 16'd1;
            demo_sig = 1'b0;
            repeat ($urandom_range(3, 6)) @(posedge clk);
            #1;
        end
        bus_read(24'd3, rd);
        checks++;
        if (rd !== 32'd3) begin failures++; $display("FAIL edgecnt_three got=%h exp=%h", rd, 32'd3); end
        // A clear that lands on the same edge as a counted rise must win.
        demo_sig = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        gb_addr = 24'd3; gb_wdata = 32'd0; gb_we = 1'b1; gb_wstb = 1'b1;
        @(posedge clk); #1;
        gb_we = 1'b0; gb_wstb = 1'b0;
        edgecnt_m = 16'd0;
        demo_sig = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus_read(24'd3, rd);
        checks++;
        if (rd !== {16'd0, edgecnt_m}) begin failures++; $display("FAIL edgecnt_clear_wins got=%h exp=%h", rd, {16'd0, edgecnt_m}); end
        $display("test_edgecnt done");
    endtask

    task automatic test_reset_midread;
        logic [31:0] rd;
        bus_write(24'd1, 32'h8000_0003);
        bus_write(24'd34, 32'h0000_005A);
        gb_addr = 24'd1; gb_rstb = 1'b1;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (gb_rdata !== 32'd0) begin failures++; $display("FAIL rst_async_rdata got=%h exp=%h", gb_rdata, 32'd0); end
        checks++;
        if (ctrl_out !== 1'b0) begin failures++; $display("FAIL rst_async_ctrl_out got=%b exp=0", ctrl_out); end
        // A write in flight while reset is high must be dropped.
        gb_rstb = 1'b0; gb_addr = 24'd34; gb_wdata = 32'h0000_00C3; gb_we = 1'b1; gb_wstb = 1'b1;
        @(posedge clk); #1;
        gb_we = 1'b0; gb_wstb = 1'b0;
        checks++;
        if (gb_rdata !== 32'd0) begin failures++; $display("FAIL rst_hold_rdata got=%h exp=%h", gb_rdata, 32'd0); end
        rst = 1'b0;
        ctrl_m = 32'd0; edgecnt_m = 16'd0;
        bus_read(24'd1, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("FAIL rst_ctrl got=%h exp=%h", rd, 32'd0); end
        bus_read(24'd34, rd);
        checks++;
        if (rd !== {24'd0, mem_m[2]}) begin failures++; $display("FAIL rst_ram_kept got=%h exp=%h", rd, {24'd0, mem_m[2]}); end
        bus_read(24'd63, rd);
        checks++;
        if (rd !== {24'd0, mem_m[31]}) begin failures++; $display("FAIL rst_ram_kept63 got=%h exp=%h", rd, {24'd0, mem_m[31]}); end
        $display("test_reset_midread done");
    endtask

    initial begin
        rst = 1'b1; gb_addr = '0; gb_wdata = '0; gb_we = 1'b0; gb_wstb = 1'b0;
        gb_rstb = 1'b0; demo_sig = 1'b0;
        for (int i = 0; i < 32; i++) mem_m[i] = 8'd0;
        @(posedge clk); #1;
        test_reset;
        test_csr;
        test_ram;
        test_addr_alias;
        test_random;
        test_edgecnt;
        test_reset_midread;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
